// File: rtl/pcap_rd_pkg.sv
// Shared definitions for the pcap byte-stream replayer.
//   GHDR_BYTES / PHDR_BYTES : pcap global / record header lengths in bytes
//   BUS_BYTES               : bytes per 80-bit packet bus word
//   MAGIC_US / MAGIC_NS     : little-endian magic values (microsecond / nanosecond files)
//   state_t                 : header parser states
package pcap_rd_pkg;

    localparam int unsigned GHDR_BYTES = 24;
    localparam int unsigned PHDR_BYTES = 16;
    localparam int unsigned BUS_BYTES  = 10;

    localparam logic [31:0] MAGIC_US = 32'hA1B2_C3D4;
    localparam logic [31:0] MAGIC_NS = 32'hA1B2_3C4D;

    typedef enum logic [2:0] {
        GHDR,
        PHDR,
        DATA,
        SKIP,
        ERROR
    } state_t;

endpackage

// File: rtl/pcap_word_pack.sv
// Packs payload bytes into 10-byte bus words and registers them onto the bus.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : in_data is a payload byte accepted this cycle
//   in_data    : payload byte
//   in_last    : this byte is the last of the packet (flushes a partial word)
//   bus_data   : packed word, byte k in bits [8k+7:8k], unused upper bytes zero
//   bus_state  : one-cycle strobe, bus_data valid
//   bus_stop   : last word of the packet (only with bus_state)
//   bus_nbytes : valid bytes in the word, 1..10
module pcap_word_pack
    import pcap_rd_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [7:0]              in_data,
    input  logic                    in_last,
    output logic [8*BUS_BYTES-1:0]  bus_data,
    output logic                    bus_state,
    output logic                    bus_stop,
    output logic [3:0]              bus_nbytes
);

    logic [8*BUS_BYTES-1:0] acc;
    logic [8*BUS_BYTES-1:0] acc_next;
    logic [3:0]             idx;
    logic                   flush;

    always_comb begin
        acc_next = acc;
        for (int unsigned k = 0; k < BUS_BYTES; k++) begin
            if (idx == 4'(k)) begin
                acc_next[8*k +: 8] = in_data;
            end
        end
        flush = in_valid && (in_last || (idx == 4'(BUS_BYTES - 1)));
    end

    // The accumulator is cleared on every flush, so bytes above the
    // write index are always zero when a partial word goes out.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            idx        <= '0;
            bus_data   <= '0;
            bus_state  <= 1'b0;
            bus_stop   <= 1'b0;
            bus_nbytes <= '0;
        end else begin
            bus_state <= flush;
            bus_stop  <= flush && in_last;
            if (flush) begin
                bus_data   <= acc_next;
                bus_nbytes <= idx + 4'd1;
                acc        <= '0;
                idx        <= '0;
            end else if (in_valid) begin
                acc <= acc_next;
                idx <= idx + 4'd1;
            end
        end
    end

endmodule

// File: rtl/pcap_bus_player.sv
// Replays a little-endian pcap byte stream onto the 80-bit packet bus.
//   clk, rst    : clock, synchronous active-high reset
//   s_data      : pcap file byte; s_valid/s_ready handshake
//   bus_data    : packet word (byte k in bits [8k+7:8k])
//   bus_state   : per-word strobe; bus_stop marks the last word; bus_nbytes 1..10
//   pkt_len     : incl_len[15:0] of the packet being replayed
//   link_type   : linktype from the global header
//   hdr_err     : sticky, global header magic not recognised
//   pkt_cnt     : packets replayed; drop_cnt : records longer than MAX_LEN
module pcap_bus_player
    import pcap_rd_pkg::*;
#(
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [79:0]       bus_data,
    output logic              bus_state,
    output logic              bus_stop,
    output logic [3:0]        bus_nbytes,
    output logic [15:0]       pkt_len,
    output logic [31:0]       link_type,
    output logic              hdr_err,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    state_t      state;
    state_t      state_next;
    logic [4:0]  hdr_idx;
    logic [31:0] magic;
    logic [31:0] incl_len;
    logic [31:0] remain;

    logic accept;
    logic ghdr_done;
    logic phdr_done;
    logic magic_ok;
    logic len_zero;
    logic len_big;
    logic last_byte;
    logic pk_valid;

    always_comb begin
        s_ready    = !rst && (state != ERROR);
        accept     = s_valid && s_ready;
        ghdr_done  = accept && (state == GHDR) && (hdr_idx == 5'(GHDR_BYTES - 1));
        phdr_done  = accept && (state == PHDR) && (hdr_idx == 5'(PHDR_BYTES - 1));
        magic_ok   = (magic == MAGIC_US) || (magic == MAGIC_NS);
        len_zero   = (incl_len == '0);
        len_big    = (incl_len > 32'(MAX_LEN));
        last_byte  = (remain == 32'd1);
        pk_valid   = accept && (state == DATA);
    end

    always_comb begin
        state_next = state;
        unique case (state)
            GHDR: if (ghdr_done) state_next = magic_ok ? PHDR : ERROR;
            PHDR: begin
                if (phdr_done) begin
                    if (len_zero)     state_next = PHDR;
                    else if (len_big) state_next = SKIP;
                    else              state_next = DATA;
                end
            end
            DATA, SKIP: if (accept && last_byte) state_next = PHDR;
            ERROR:      state_next = ERROR;
            default:    state_next = ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= GHDR;
        else     state <= state_next;
    end

    // Header fields are shifted in from the top so that four consecutive
    // little-endian bytes end up as the natural 32-bit value.
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_idx   <= '0;
            magic     <= '0;
            incl_len  <= '0;
            remain    <= '0;
            pkt_len   <= '0;
            link_type <= '0;
            hdr_err   <= 1'b0;
            pkt_cnt   <= '0;
            drop_cnt  <= '0;
        end else if (accept) begin
            unique case (state)
                GHDR: begin
                    hdr_idx <= ghdr_done ? 5'd0 : hdr_idx + 5'd1;
                    if (hdr_idx < 5'd4)  magic     <= {s_data, magic[31:8]};
                    if (hdr_idx >= 5'd20) link_type <= {s_data, link_type[31:8]};
                    if (ghdr_done && !magic_ok) hdr_err <= 1'b1;
                end
                PHDR: begin
                    hdr_idx <= phdr_done ? 5'd0 : hdr_idx + 5'd1;
                    if (hdr_idx >= 5'd8 && hdr_idx <= 5'd11) begin
                        incl_len <= {s_data, incl_len[31:8]};
                    end
                    if (phdr_done && !len_zero) begin
                        remain <= incl_len;
                        if (len_big) drop_cnt <= drop_cnt + CNT_W'(1);
                        else         pkt_len  <= incl_len[15:0];
                    end
                end
                DATA: begin
                    remain <= remain - 32'd1;
                    if (last_byte) pkt_cnt <= pkt_cnt + CNT_W'(1);
                end
                SKIP:    remain <= remain - 32'd1;
                default: ;
            endcase
        end
    end

    pcap_word_pack u_pack (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (pk_valid),
        .in_data    (s_data),
        .in_last    (last_byte),
        .bus_data   (bus_data),
        .bus_state  (bus_state),
        .bus_stop   (bus_stop),
        .bus_nbytes (bus_nbytes)
    );

endmodule

// File: tb/tb_pcap_bus_player.sv
module tb_pcap_bus_player;

    localparam int MAX_LEN = 1518;
    localparam int CNT_W   = 32;

    logic              clk;
    logic              rst;
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic [79:0]       bus_data;
    logic              bus_state;
    logic              bus_stop;
    logic [3:0]        bus_nbytes;
    logic [15:0]       pkt_len;
    logic [31:0]       link_type;
    logic              hdr_err;
    logic [CNT_W-1:0]  pkt_cnt;
    logic [CNT_W-1:0]  drop_cnt;

    pcap_bus_player #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .bus_data(bus_data), .bus_state(bus_state), .bus_stop(bus_stop),
        .bus_nbytes(bus_nbytes), .pkt_len(pkt_len), .link_type(link_type),
        .hdr_err(hdr_err), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [79:0] data;
        logic [3:0]  nb;
        logic        stop;
    } word_t;

    int           n_cmp;
    int           n_err;
    int           cyc;
    int           stop_viol;
    int           exp_pkts;
    int           exp_drops;
    byte unsigned stream[$];
    word_t        exp_q[$];
    word_t        obs_q[$];
    int           obs_cyc[$];
    word_t        mon_w;

    // Bus monitor: every strobed word is recorded with its cycle number.
    always @(negedge clk) begin
        cyc++;
        if (bus_state) begin
            mon_w.data = bus_data;
            mon_w.nb   = bus_nbytes;
            mon_w.stop = bus_stop;
            obs_q.push_back(mon_w);
            obs_cyc.push_back(cyc);
        end
        if (bus_stop && !bus_state) stop_viol++;
    end

    task automatic push32(input logic [31:0] v);
        for (int b = 0; b < 4; b++) stream.push_back(v[8*b +: 8]);
    endtask

    task automatic add_ghdr(input logic [31:0] magic, input logic [31:0] lt);
        push32(magic);
        push32(32'h0004_0002);
        push32(32'h0);
        push32(32'h0);
        push32(32'h0000_FFFF);
        push32(lt);
    endtask

    // Appends a record and derives its expected bus words by chunking the
    // payload into groups of ten bytes.
    task automatic add_record(input int len, input int rnd, input int base);
        byte unsigned pl[$];
        word_t        e;
        int           nw;
        int           n;
        push32($urandom);
        push32($urandom);
        push32(len);
        push32(len);
        for (int i = 0; i < len; i++) begin
            byte unsigned b;
            b = rnd ? 8'($urandom_range(0, 255)) : 8'((base + i) & 255);
            pl.push_back(b);
            stream.push_back(b);
        end
        if (len > MAX_LEN) begin
            exp_drops++;
        end else if (len > 0) begin
            exp_pkts++;
            nw = (len + 9) / 10;
            for (int w = 0; w < nw; w++) begin
                n = (len - 10*w > 10) ? 10 : len - 10*w;
                e.data = '0;
                for (int j = 0; j < n; j++) e.data[8*j +: 8] = pl[10*w + j];
                e.nb   = 4'(n);
                e.stop = (w == nw - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic clear_q();
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    // mode 0: full rate, 1: s_valid toggles every cycle, 2: random stalls.
    task automatic run_stream(input int mode, input int limit);
        int  i;
        int  c;
        int  nb;
        int  maxc;
        logic v;
        logic acc;
        i    = 0;
        c    = 0;
        nb   = (limit < 0) ? stream.size() : limit;
        maxc = 4 * nb + 100;
        while (i < nb && c < maxc) begin
            @(negedge clk);
            c++;
            case (mode)
                0:       v = 1'b1;
                1:       v = (c % 2) == 1;
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            s_valid = v;
            s_data  = stream[i];
            #1;
            acc = v && s_ready;
            @(posedge clk);
            if (acc) i++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        n_cmp++;
        if (i !== nb) begin
            n_err++;
            $display("FAIL stream_consumed: accepted %0d bytes, required %0d", i, nb);
        end
        stream.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_q();
        exp_pkts  = 0;
        exp_drops = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hD4;
        #1;
        n_cmp++;
        if (s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready_low: got %b, want 0", s_ready);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus_data, bus_state, bus_stop, bus_nbytes, pkt_len, link_type, hdr_err,
             pkt_cnt, drop_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: data=%h st=%b sp=%b nb=%0d len=%0d lt=%0d he=%b pc=%0d dc=%0d, want all 0",
                     bus_data, bus_state, bus_stop, bus_nbytes, pkt_len, link_type, hdr_err,
                     pkt_cnt, drop_cnt);
        end
        rst     = 1'b0;
        s_valid = 1'b0;
        #1;
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready_high: got %b, want 1", s_ready);
        end
        clear_q();
        exp_pkts  = 0;
        exp_drops = 0;
    endtask

    task automatic test_basic();
        logic [79:0] w0;
        w0 = 80'h09_08_07_06_05_04_03_02_01_00;
        clear_q();
        add_ghdr(32'hA1B2C3D4, 32'd1);
        add_record(40, 0, 0);
        run_stream(0, -1);
        n_cmp++;
        if (link_type !== 32'd1) begin
            n_err++;
            $display("FAIL basic_link_type: got %0d, want 1", link_type);
        end
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_err++;
            $display("FAIL basic_word_count: got %0d, want %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            n_cmp++;
            if ({obs_q[k].data, obs_q[k].nb, obs_q[k].stop} !== {exp_q[k].data, exp_q[k].nb, exp_q[k].stop}) begin
                n_err++;
                $display("FAIL basic_word%0d: got %h/%0d/%b, want %h/%0d/%b", k, obs_q[k].data,
                         obs_q[k].nb, obs_q[k].stop, exp_q[k].data, exp_q[k].nb, exp_q[k].stop);
            end
        end
        if (obs_q.size() > 0) begin
            n_cmp++;
            if (obs_q[0].data !== w0) begin
                n_err++;
                $display("FAIL basic_first_word: got %h, want %h", obs_q[0].data, w0);
            end
        end
        for (int k = 1; k < obs_cyc.size(); k++) begin
            n_cmp++;
            if (obs_cyc[k] - obs_cyc[k-1] !== 10) begin
                n_err++;
                $display("FAIL basic_spacing%0d: got %0d cycles, want 10", k, obs_cyc[k] - obs_cyc[k-1]);
            end
        end
        n_cmp++;
        if (pkt_cnt !== CNT_W'(exp_pkts) || pkt_len !== 16'd40) begin
            n_err++;
            $display("FAIL basic_counts: pkt_cnt=%0d pkt_len=%0d, want %0d and 40", pkt_cnt, pkt_len, exp_pkts);
        end
    endtask

    task automatic test_partial();
        logic [79:0] wl;
        wl = 80'h00_00_00_00_00_58_57_56_55_54;
        clear_q();
        add_record(25, 0, 8'h40);
        run_stream(0, -1);
        n_cmp++;
        if (obs_q.size() !== 3) begin
            n_err++;
            $display("FAIL partial_word_count: got %0d, want 3", obs_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            n_cmp++;
            if ({obs_q[k].data, obs_q[k].nb, obs_q[k].stop} !== {exp_q[k].data, exp_q[k].nb, exp_q[k].stop}) begin
                n_err++;
                $display("FAIL partial_word%0d: got %h/%0d/%b, want %h/%0d/%b", k, obs_q[k].data,
                         obs_q[k].nb, obs_q[k].stop, exp_q[k].data, exp_q[k].nb, exp_q[k].stop);
            end
        end
        if (obs_q.size() == 3) begin
            n_cmp++;
            if ({obs_q[2].data, obs_q[2].nb, obs_q[2].stop} !== {wl, 4'd5, 1'b1}) begin
                n_err++;
                $display("FAIL partial_last_word: got %h/%0d/%b, want %h/5/1", obs_q[2].data,
                         obs_q[2].nb, obs_q[2].stop, wl);
            end
        end
        n_cmp++;
        if (pkt_cnt !== CNT_W'(exp_pkts) || pkt_len !== 16'd25) begin
            n_err++;
            $display("FAIL partial_counts: pkt_cnt=%0d pkt_len=%0d, want %0d and 25", pkt_cnt, pkt_len, exp_pkts);
        end
    endtask

    task automatic test_drop();
        clear_q();
        add_record(2000, 1, 0);
        add_record(0, 0, 0);
        add_record(10, 1, 0);
        run_stream(0, -1);
        n_cmp++;
        if (drop_cnt !== CNT_W'(1)) begin
            n_err++;
            $display("FAIL drop_count: got %0d, want 1", drop_cnt);
        end
        n_cmp++;
        if (obs_q.size() !== 1) begin
            n_err++;
            $display("FAIL drop_word_count: got %0d, want 1", obs_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            n_cmp++;
            if ({obs_q[k].data, obs_q[k].nb, obs_q[k].stop} !== {exp_q[k].data, 4'd10, 1'b1}) begin
                n_err++;
                $display("FAIL drop_word%0d: got %h/%0d/%b, want %h/10/1", k, obs_q[k].data,
                         obs_q[k].nb, obs_q[k].stop, exp_q[k].data);
            end
        end
        n_cmp++;
        if (pkt_cnt !== CNT_W'(exp_pkts) || pkt_len !== 16'd10) begin
            n_err++;
            $display("FAIL drop_counts: pkt_cnt=%0d pkt_len=%0d, want %0d and 10", pkt_cnt, pkt_len, exp_pkts);
        end
    endtask

    task automatic test_random();
        clear_q();
        for (int r = 0; r < 8; r++) add_record($urandom_range(0, 45), 1, 0);
        run_stream(2, -1);
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_err++;
            $display("FAIL random_word_count: got %0d, want %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            n_cmp++;
            if ({obs_q[k].data, obs_q[k].nb, obs_q[k].stop} !== {exp_q[k].data, exp_q[k].nb, exp_q[k].stop}) begin
                n_err++;
                $display("FAIL random_word%0d: got %h/%0d/%b, want %h/%0d/%b", k, obs_q[k].data,
                         obs_q[k].nb, obs_q[k].stop, exp_q[k].data, exp_q[k].nb, exp_q[k].stop);
            end
        end
        n_cmp++;
        if (pkt_cnt !== CNT_W'(exp_pkts) || drop_cnt !== CNT_W'(exp_drops)) begin
            n_err++;
            $display("FAIL random_counts: pkt_cnt=%0d drop_cnt=%0d, want %0d and %0d",
                     pkt_cnt, drop_cnt, exp_pkts, exp_drops);
        end
    endtask

    task automatic test_stall();
        do_reset();
        add_ghdr(32'hA1B2C3D4, 32'd1);
        add_record(40, 0, 0);
        run_stream(1, -1);
        n_cmp++;
        if (obs_q.size() !== 4) begin
            n_err++;
            $display("FAIL stall_word_count: got %0d, want 4", obs_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            n_cmp++;
            if ({obs_q[k].data, obs_q[k].nb, obs_q[k].stop} !== {exp_q[k].data, exp_q[k].nb, exp_q[k].stop}) begin
                n_err++;
                $display("FAIL stall_word%0d: got %h/%0d/%b, want %h/%0d/%b", k, obs_q[k].data,
                         obs_q[k].nb, obs_q[k].stop, exp_q[k].data, exp_q[k].nb, exp_q[k].stop);
            end
        end
        for (int k = 1; k < obs_cyc.size(); k++) begin
            n_cmp++;
            if (obs_cyc[k] - obs_cyc[k-1] !== 20) begin
                n_err++;
                $display("FAIL stall_spacing%0d: got %0d cycles, want 20", k, obs_cyc[k] - obs_cyc[k-1]);
            end
        end
    endtask

    task automatic test_rst_mid();
        word_t first;
        do_reset();
        add_ghdr(32'hA1B2C3D4, 32'd1);
        add_record(40, 1, 0);
        first = exp_q[0];
        run_stream(0, 24 + 16 + 15);
        n_cmp++;
        if (obs_q.size() !== 1) begin
            n_err++;
            $display("FAIL rstmid_pre_words: got %0d, want 1", obs_q.size());
        end else begin
            n_cmp++;
            if (obs_q[0].data !== first.data || obs_q[0].stop !== 1'b0) begin
                n_err++;
                $display("FAIL rstmid_pre_word: got %h/%b, want %h/0", obs_q[0].data, obs_q[0].stop, first.data);
            end
        end
        do_reset();
        repeat (5) @(negedge clk);
        n_cmp++;
        if (obs_q.size() !== 0 || pkt_cnt !== '0) begin
            n_err++;
            $display("FAIL rstmid_flushed: words=%0d pkt_cnt=%0d, want 0 and 0", obs_q.size(), pkt_cnt);
        end
        add_ghdr(32'hA1B23C4D, 32'd105);
        add_record(23, 1, 0);
        run_stream(2, -1);
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_err++;
            $display("FAIL rstmid_word_count: got %0d, want %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            n_cmp++;
            if ({obs_q[k].data, obs_q[k].nb, obs_q[k].stop} !== {exp_q[k].data, exp_q[k].nb, exp_q[k].stop}) begin
                n_err++;
                $display("FAIL rstmid_word%0d: got %h/%0d/%b, want %h/%0d/%b", k, obs_q[k].data,
                         obs_q[k].nb, obs_q[k].stop, exp_q[k].data, exp_q[k].nb, exp_q[k].stop);
            end
        end
        n_cmp++;
        if (pkt_cnt !== CNT_W'(1) || drop_cnt !== '0 || link_type !== 32'd105) begin
            n_err++;
            $display("FAIL rstmid_counts: pkt_cnt=%0d drop_cnt=%0d link_type=%0d, want 1, 0, 105",
                     pkt_cnt, drop_cnt, link_type);
        end
    endtask

    task automatic test_bad_magic();
        int ready_hi;
        do_reset();
        add_ghdr(32'h0403_0201, 32'd1);
        run_stream(0, -1);
        n_cmp++;
        if (hdr_err !== 1'b1) begin
            n_err++;
            $display("FAIL badmagic_hdr_err: got %b, want 1", hdr_err);
        end
        ready_hi = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = 8'($urandom_range(0, 255));
            #1;
            if (s_ready !== 1'b0) ready_hi++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        n_cmp++;
        if (ready_hi !== 0) begin
            n_err++;
            $display("FAIL badmagic_ready: s_ready high %0d cycles, want 0", ready_hi);
        end
        n_cmp++;
        if (obs_q.size() !== 0 || pkt_cnt !== '0) begin
            n_err++;
            $display("FAIL badmagic_bus_idle: words=%0d pkt_cnt=%0d, want 0 and 0", obs_q.size(), pkt_cnt);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        cyc       = 0;
        stop_viol = 0;
        exp_pkts  = 0;
        exp_drops = 0;
        rst       = 1'b1;
        s_valid   = 1'b0;
        s_data    = '0;
        test_reset();
        test_basic();
        test_partial();
        test_drop();
        test_random();
        test_stall();
        test_rst_mid();
        test_bad_magic();
        n_cmp++;
        if (stop_viol !== 0) begin
            n_err++;
            $display("FAIL stop_without_state: got %0d cycles, want 0", stop_viol);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
